// File: rtl/ethernet_pkg.sv
// Shared definitions for the Ethernet host bridge: controller register map,
// default MTU and the bridge FSM state encoding.
package ethernet_pkg;

    localparam int unsigned ETH_MTU_DEFAULT    = 2048;
    localparam logic [13:0] RX_BUF_BASE_DEFAULT = 14'h0000;
    localparam logic [13:0] TX_BUF_BASE_DEFAULT = 14'h0800;
    localparam logic [13:0] RX_SIZE_ADDR_DEFAULT = 14'h1004;
    localparam logic [13:0] RX_ACK_ADDR_DEFAULT = 14'h1008;
    localparam logic [13:0] TX_STATUS_ADDR_DEFAULT = 14'h1010;
    localparam logic [13:0] TX_SIZE_ADDR_DEFAULT = 14'h1014;
    localparam logic [13:0] TX_SEND_ADDR_DEFAULT = 14'h1018;

    typedef enum logic [3:0] {
        IDLE,
        TX_POLL,
        TX_POLL_RESP,
        TX_DATA,
        TX_SIZE,
        TX_SEND,
        RX_SIZE,
        RX_SIZE_RESP,
        RX_READ,
        RX_RESP,
        RX_ACK
    } bridge_state_e;

endpackage

// File: rtl/ethernet_host_bridge.sv
// Stream-to-MMIO initiator: pushes TX word streams into the controller's packet
// buffer and drains received packets back out as an RX word stream.
module ethernet_host_bridge
    import ethernet_pkg::*;
#(
    parameter int unsigned data_width_p     = 32,
    parameter int unsigned eth_mtu_p        = ETH_MTU_DEFAULT,
    parameter logic [13:0] rx_buf_base_p    = RX_BUF_BASE_DEFAULT,
    parameter logic [13:0] tx_buf_base_p    = TX_BUF_BASE_DEFAULT,
    parameter logic [13:0] rx_size_addr_p   = RX_SIZE_ADDR_DEFAULT,
    parameter logic [13:0] rx_ack_addr_p    = RX_ACK_ADDR_DEFAULT,
    parameter logic [13:0] tx_status_addr_p = TX_STATUS_ADDR_DEFAULT,
    parameter logic [13:0] tx_size_addr_p   = TX_SIZE_ADDR_DEFAULT,
    parameter logic [13:0] tx_send_addr_p   = TX_SEND_ADDR_DEFAULT
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [data_width_p-1:0]                  tx_data_i,
    input  logic                                     tx_last_i,
    input  logic                                     tx_v_i,
    output logic                                     tx_ready_and_o,
    output logic [data_width_p-1:0]                  rx_data_o,
    output logic                                     rx_last_o,
    output logic [11:0]                              rx_size_o,
    output logic                                     rx_v_o,
    input  logic                                     rx_ready_and_i,
    output logic [13:0]                              addr_o,
    output logic                                     write_en_o,
    output logic                                     read_en_o,
    output logic [$clog2($clog2(data_width_p/8)):0]  op_size_o,
    output logic [data_width_p-1:0]                  write_data_o,
    input  logic [data_width_p-1:0]                  read_data_i,
    input  logic                                     rx_interrupt_pending_i,
    output logic                                     tx_error_o
);

    localparam int unsigned B     = data_width_p / 8;
    localparam int unsigned LG_B  = $clog2(B);
    localparam int unsigned OPS_W = $clog2($clog2(B)) + 1;
    localparam int unsigned IDX_W = $clog2(eth_mtu_p / B) + 1;
    localparam logic [IDX_W-1:0] MTU_WORDS = IDX_W'(eth_mtu_p / B);

    bridge_state_e             state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [IDX_W-1:0]          rxWords_q;
    logic [IDX_W-1:0]          rxWords_d;
    logic                      lastGrantRx_q;
    logic                      overflow_q;
    logic                      respFirst_q;
    logic [11:0]               rxSize_q;
    logic [11:0]               rxSize_d;
    logic [12:0]               rxRound;
    logic [data_width_p-1:0]   rxHold_q;
    logic [data_width_p-1:0]   txBytes;
    logic [13:0]               wordOffset;

    always_comb begin
        wordOffset = 14'(idx_q) << LG_B;
        if (read_data_i > data_width_p'(eth_mtu_p)) begin
            rxSize_d = 12'(eth_mtu_p);
        end else begin
            rxSize_d = read_data_i[11:0];
        end
        rxRound   = {1'b0, rxSize_d} + 13'(B - 1);
        rxWords_d = IDX_W'(rxRound >> LG_B);
        txBytes   = overflow_q ? data_width_p'(eth_mtu_p) : (data_width_p'(idx_q) << LG_B);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            rxWords_q     <= '0;
            lastGrantRx_q <= 1'b1;
            overflow_q    <= 1'b0;
            respFirst_q   <= 1'b0;
            rxSize_q      <= '0;
            rxHold_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_q      <= '0;
                    overflow_q <= 1'b0;
                    // Round-robin: on a tie, serve whichever side was not granted last.
                    if (tx_v_i && (!rx_interrupt_pending_i || lastGrantRx_q)) begin
                        state_q <= TX_POLL;
                    end else if (rx_interrupt_pending_i) begin
                        state_q <= RX_SIZE;
                    end
                end
                TX_POLL:      state_q <= TX_POLL_RESP;
                TX_POLL_RESP: state_q <= read_data_i[0] ? TX_DATA : TX_POLL;
                TX_DATA: begin
                    if (tx_v_i) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q >= MTU_WORDS) begin
                            overflow_q <= 1'b1;
                        end
                        if (tx_last_i) begin
                            state_q <= TX_SIZE;
                        end
                    end
                end
                TX_SIZE: state_q <= TX_SEND;
                TX_SEND: begin
                    state_q       <= IDLE;
                    lastGrantRx_q <= 1'b0;
                end
                RX_SIZE: state_q <= RX_SIZE_RESP;
                RX_SIZE_RESP: begin
                    rxSize_q  <= rxSize_d;
                    rxWords_q <= rxWords_d;
                    state_q   <= (rxSize_d == 12'd0) ? RX_ACK : RX_READ;
                end
                RX_READ: begin
                    respFirst_q <= 1'b1;
                    state_q     <= RX_RESP;
                end
                RX_RESP: begin
                    // Read data is only valid for one cycle, so keep a copy for stalls.
                    respFirst_q <= 1'b0;
                    if (respFirst_q) begin
                        rxHold_q <= read_data_i;
                    end
                    if (rx_ready_and_i) begin
                        if (idx_q == rxWords_q - 1'b1) begin
                            state_q <= RX_ACK;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= RX_READ;
                        end
                    end
                end
                RX_ACK: begin
                    state_q       <= IDLE;
                    lastGrantRx_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        addr_o       = '0;
        write_en_o   = 1'b0;
        read_en_o    = 1'b0;
        write_data_o = '0;
        case (state_q)
            TX_POLL: begin
                read_en_o = 1'b1;
                addr_o    = tx_status_addr_p;
            end
            TX_DATA: begin
                if (tx_v_i && (idx_q < MTU_WORDS)) begin
                    write_en_o   = 1'b1;
                    addr_o       = tx_buf_base_p + wordOffset;
                    write_data_o = tx_data_i;
                end
            end
            TX_SIZE: begin
                write_en_o   = 1'b1;
                addr_o       = tx_size_addr_p;
                write_data_o = txBytes;
            end
            TX_SEND: begin
                write_en_o   = 1'b1;
                addr_o       = tx_send_addr_p;
                write_data_o = data_width_p'(1);
            end
            RX_SIZE: begin
                read_en_o = 1'b1;
                addr_o    = rx_size_addr_p;
            end
            RX_READ: begin
                read_en_o = 1'b1;
                addr_o    = rx_buf_base_p + wordOffset;
            end
            RX_ACK: begin
                write_en_o   = 1'b1;
                addr_o       = rx_ack_addr_p;
                write_data_o = data_width_p'(1);
            end
            default: ;
        endcase
    end

    assign op_size_o      = OPS_W'(LG_B);
    assign tx_ready_and_o = (state_q == TX_DATA);
    assign tx_error_o     = (state_q == TX_SEND) && overflow_q;
    assign rx_v_o         = (state_q == RX_RESP);
    assign rx_last_o      = (state_q == RX_RESP) && (idx_q == rxWords_q - 1'b1);
    assign rx_data_o      = respFirst_q ? read_data_i : rxHold_q;
    assign rx_size_o      = rxSize_q;

endmodule

// File: tb/tb_ethernet_host_bridge.sv
// Directed bench for ethernet_host_bridge with a small controller model that
// answers MMIO reads and logs every MMIO access in order.
module tb_ethernet_host_bridge;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] tx_data_i;
    logic        tx_last_i;
    logic        tx_v_i;
    logic        tx_ready_and_o;
    logic [31:0] rx_data_o;
    logic        rx_last_o;
    logic [11:0] rx_size_o;
    logic        rx_v_o;
    logic        rx_ready_and_i;
    logic [13:0] addr_o;
    logic        write_en_o;
    logic        read_en_o;
    logic [1:0]  op_size_o;
    logic [31:0] write_data_o;
    logic [31:0] read_data_i;
    logic        rx_interrupt_pending_i;
    logic        tx_error_o;

    int errors = 0;
    int checks = 0;

    logic [13:0] opAddr[$];
    logic [31:0] opData[$];
    logic        opWr[$];
    int          pollCount = 0;
    int          pollBase = 0;
    int          pollZeros = 0;
    int          readyEarly = 0;
    int          errCount = 0;
    int          errWithSend = 0;
    int          rxVCount = 0;
    int          rxPostCount = 0;
    int          rxAckCount = 0;
    logic [31:0] rxSizeVal = 32'd0;
    logic        rdPend = 1'b0;
    logic [31:0] rdVal = 32'd0;

    always #5 clk = ~clk;

    assign rx_interrupt_pending_i = (rxPostCount != rxAckCount);

    ethernet_host_bridge dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .tx_data_i(tx_data_i),
        .tx_last_i(tx_last_i),
        .tx_v_i(tx_v_i),
        .tx_ready_and_o(tx_ready_and_o),
        .rx_data_o(rx_data_o),
        .rx_last_o(rx_last_o),
        .rx_size_o(rx_size_o),
        .rx_v_o(rx_v_o),
        .rx_ready_and_i(rx_ready_and_i),
        .addr_o(addr_o),
        .write_en_o(write_en_o),
        .read_en_o(read_en_o),
        .op_size_o(op_size_o),
        .write_data_o(write_data_o),
        .read_data_i(read_data_i),
        .rx_interrupt_pending_i(rx_interrupt_pending_i),
        .tx_error_o(tx_error_o)
    );

    // Controller model: observe the MMIO port mid-cycle, answer reads one edge later.
    initial forever begin
        @(negedge clk);
        rdPend = 1'b0;
        if (read_en_o) begin
            opAddr.push_back(addr_o);
            opData.push_back(32'h0);
            opWr.push_back(1'b0);
            rdPend = 1'b1;
            if (addr_o == 14'h1010) begin
                rdVal = ((pollCount - pollBase) < pollZeros) ? 32'd0 : 32'd1;
                pollCount++;
            end else if (addr_o == 14'h1004) begin
                rdVal = rxSizeVal;
            end else begin
                rdVal = 32'hA5000000 | {18'h0, addr_o};
            end
        end
        if (write_en_o) begin
            opAddr.push_back(addr_o);
            opData.push_back(write_data_o);
            opWr.push_back(1'b1);
            if (addr_o == 14'h1008) rxAckCount++;
            if (addr_o == 14'h1018 && tx_error_o) errWithSend++;
        end
        if (tx_error_o) errCount++;
        if (tx_ready_and_o && (pollCount - pollBase) < 3) readyEarly++;
        if (rx_v_o) rxVCount++;
    end

    initial forever begin
        @(posedge clk);
        read_data_i <= rdPend ? rdVal : 32'hDEADBEEF;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exceeded, want completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitAccept(output bit ok);
        int w = 0;
        ok = 1'b1;
        do begin
            @(negedge clk);
            w++;
        end while (!tx_ready_and_o && w < 200);
        checks++;
        if (!tx_ready_and_o) begin
            errors++;
            ok = 1'b0;
            $display("[TB] FAIL tx_accept_timeout: ready=%b after %0d cycles, want 1", tx_ready_and_o, w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendTx(input int n, input logic [31:0] base);
        bit ok;
        for (int i = 0; i < n; i++) begin
            tx_data_i = base + 32'(i);
            tx_last_i = (i == n - 1);
            tx_v_i    = 1'b1;
            waitAccept(ok);
            if (!ok) break;
        end
        tx_v_i    = 1'b0;
        tx_last_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i        = 1'b1;
        tx_v_i         = 1'b0;
        tx_last_i      = 1'b0;
        tx_data_i      = 32'h0;
        rx_ready_and_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({write_en_o, read_en_o, tx_ready_and_o, rx_v_o, tx_error_o} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got we=%b re=%b rdy=%b rxv=%b err=%b, want all 0",
                     write_en_o, read_en_o, tx_ready_and_o, rx_v_o, tx_error_o);
        end
        checks++;
        if (addr_o !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset_addr: got %h want 0000", addr_o);
        end
        checks++;
        if (write_data_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_wdata: got %h want 00000000", write_data_o);
        end
        checks++;
        if (rx_size_o !== 12'h0) begin
            errors++;
            $display("[TB] FAIL reset_rx_size: got %0d want 0", rx_size_o);
        end
        checks++;
        if (op_size_o !== 2'd2) begin
            errors++;
            $display("[TB] FAIL op_size: got %0d want 2", op_size_o);
        end
    endtask

    task automatic test_tx_basic();
        logic [13:0] ea[6] = '{14'h1010, 14'h0800, 14'h0804, 14'h0808, 14'h1014, 14'h1018};
        logic        ew[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] ed[6] = '{32'h0, 32'h11110000, 32'h11110001, 32'h11110002, 32'd12, 32'd1};
        int s  = opAddr.size();
        int e0 = errCount;
        pollZeros = 0;
        sendTx(3, 32'h11110000);
        idle(5);
        checks++;
        if (opAddr.size() - s !== 6) begin
            errors++;
            $display("[TB] FAIL tx_basic_count: got %0d accesses want 6", opAddr.size() - s);
        end
        for (int i = 0; i < 6; i++) begin
            if (s + i < opAddr.size()) begin
                checks++;
                if ({opAddr[s+i], opWr[s+i], opData[s+i]} !== {ea[i], ew[i], ed[i]}) begin
                    errors++;
                    $display("[TB] FAIL tx_basic_op%0d: got addr=%h wr=%b data=%h want addr=%h wr=%b data=%h",
                             i, opAddr[s+i], opWr[s+i], opData[s+i], ea[i], ew[i], ed[i]);
                end
            end
        end
        checks++;
        if (errCount - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL tx_basic_error: got %0d pulses want 0", errCount - e0);
        end
    endtask

    task automatic test_tx_poll();
        logic [13:0] ea[7] = '{14'h1010, 14'h1010, 14'h1010, 14'h0800, 14'h0804, 14'h1014, 14'h1018};
        logic [31:0] ed[7] = '{32'h0, 32'h0, 32'h0, 32'h22220000, 32'h22220001, 32'd8, 32'd1};
        int s  = opAddr.size();
        int re = readyEarly;
        pollBase  = pollCount;
        pollZeros = 2;
        sendTx(2, 32'h22220000);
        idle(5);
        checks++;
        if (pollCount - pollBase !== 3) begin
            errors++;
            $display("[TB] FAIL tx_poll_count: got %0d polls want 3", pollCount - pollBase);
        end
        checks++;
        if (readyEarly - re !== 0) begin
            errors++;
            $display("[TB] FAIL tx_poll_ready_early: got %0d ready cycles want 0", readyEarly - re);
        end
        checks++;
        if (opAddr.size() - s !== 7) begin
            errors++;
            $display("[TB] FAIL tx_poll_ops: got %0d accesses want 7", opAddr.size() - s);
        end
        for (int i = 0; i < 7; i++) begin
            if (s + i < opAddr.size()) begin
                checks++;
                if ({opAddr[s+i], opData[s+i]} !== {ea[i], ed[i]}) begin
                    errors++;
                    $display("[TB] FAIL tx_poll_op%0d: got addr=%h data=%h want addr=%h data=%h",
                             i, opAddr[s+i], opData[s+i], ea[i], ed[i]);
                end
            end
        end
        pollZeros = 0;
    endtask

    task automatic test_tx_overflow();
        int s   = opAddr.size();
        int e0  = errCount;
        int ews = errWithSend;
        int nData = 0;
        pollZeros = 0;
        sendTx(514, 32'h5A000000);
        idle(5);
        for (int i = s; i < opAddr.size(); i++) begin
            if (opWr[i] && opAddr[i] >= 14'h0800 && opAddr[i] < 14'h1000) nData++;
        end
        checks++;
        if (nData !== 512) begin
            errors++;
            $display("[TB] FAIL tx_ovf_data_writes: got %0d want 512", nData);
        end
        checks++;
        if (opAddr.size() - s !== 515) begin
            errors++;
            $display("[TB] FAIL tx_ovf_ops: got %0d accesses want 515", opAddr.size() - s);
        end
        if (opAddr.size() - s >= 515) begin
            checks++;
            if ({opAddr[s+512], opData[s+512]} !== {14'h0FFC, 32'h5A0001FF}) begin
                errors++;
                $display("[TB] FAIL tx_ovf_last_data: got addr=%h data=%h want addr=0ffc data=5a0001ff",
                         opAddr[s+512], opData[s+512]);
            end
            checks++;
            if ({opAddr[s+513], opData[s+513]} !== {14'h1014, 32'd2048}) begin
                errors++;
                $display("[TB] FAIL tx_ovf_size: got addr=%h data=%0d want addr=1014 data=2048",
                         opAddr[s+513], opData[s+513]);
            end
            checks++;
            if (opAddr[s+514] !== 14'h1018) begin
                errors++;
                $display("[TB] FAIL tx_ovf_send: got addr=%h want 1018", opAddr[s+514]);
            end
        end
        checks++;
        if ((errCount - e0 !== 1) || (errWithSend - ews !== 1)) begin
            errors++;
            $display("[TB] FAIL tx_ovf_error: got %0d pulses (%0d with send) want 1 (1)",
                     errCount - e0, errWithSend - ews);
        end
    endtask

    task automatic test_rx();
        logic [13:0] ea[5] = '{14'h1004, 14'h0000, 14'h0004, 14'h0008, 14'h1008};
        logic [31:0] ed[5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'd1};
        int s = opAddr.size();
        int got = 0;
        int stall = 0;
        int cyc = 0;
        rxSizeVal      = 32'd10;
        rx_ready_and_i = 1'b0;
        rxPostCount++;
        while (got < 3 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (rx_v_o) begin
                if (got == 0 && stall < 5) begin
                    rx_ready_and_i = 1'b0;
                    stall++;
                    checks++;
                    if ({rx_data_o, rx_last_o} !== {32'hA5000000, 1'b0}) begin
                        errors++;
                        $display("[TB] FAIL rx_hold%0d: got data=%h last=%b want data=a5000000 last=0",
                                 stall, rx_data_o, rx_last_o);
                    end
                end else begin
                    rx_ready_and_i = 1'b1;
                    checks++;
                    if ({rx_data_o, rx_last_o, rx_size_o} !== {32'hA5000000 + 32'(4 * got), (got == 2), 12'd10}) begin
                        errors++;
                        $display("[TB] FAIL rx_word%0d: got data=%h last=%b size=%0d want data=%h last=%b size=10",
                                 got, rx_data_o, rx_last_o, rx_size_o, 32'hA5000000 + 32'(4 * got), (got == 2));
                    end
                    got++;
                end
            end else begin
                rx_ready_and_i = 1'b0;
            end
        end
        checks++;
        if (got !== 3) begin
            errors++;
            $display("[TB] FAIL rx_timeout: got %0d words want 3", got);
        end
        @(posedge clk);
        #1 rx_ready_and_i = 1'b0;
        idle(4);
        checks++;
        if (opAddr.size() - s !== 5) begin
            errors++;
            $display("[TB] FAIL rx_ops: got %0d accesses want 5", opAddr.size() - s);
        end
        for (int i = 0; i < 5; i++) begin
            if (s + i < opAddr.size()) begin
                checks++;
                if ({opAddr[s+i], opData[s+i]} !== {ea[i], ed[i]}) begin
                    errors++;
                    $display("[TB] FAIL rx_op%0d: got addr=%h data=%h want addr=%h data=%h",
                             i, opAddr[s+i], opData[s+i], ea[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] ea[6] = '{14'h1004, 14'h1008, 14'h1010, 14'h0800, 14'h1014, 14'h1018};
        logic [31:0] ed[6] = '{32'h0, 32'd1, 32'h0, 32'h77770000, 32'd4, 32'd1};
        int s;
        int v0;
        pollZeros = 0;
        sendTx(1, 32'h66660000);
        idle(3);
        s  = opAddr.size();
        v0 = rxVCount;
        rxSizeVal = 32'd0;
        rxPostCount++;
        sendTx(1, 32'h77770000);
        idle(5);
        checks++;
        if (opAddr.size() - s !== 6) begin
            errors++;
            $display("[TB] FAIL arb_ops: got %0d accesses want 6", opAddr.size() - s);
        end
        for (int i = 0; i < 6; i++) begin
            if (s + i < opAddr.size()) begin
                checks++;
                if ({opAddr[s+i], opData[s+i]} !== {ea[i], ed[i]}) begin
                    errors++;
                    $display("[TB] FAIL arb_op%0d: got addr=%h data=%h want addr=%h data=%h",
                             i, opAddr[s+i], opData[s+i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (rxVCount - v0 !== 0) begin
            errors++;
            $display("[TB] FAIL rx_zero_valid: got %0d valid cycles want 0", rxVCount - v0);
        end
    endtask

    task automatic test_reset_abort();
        logic [13:0] ea[4] = '{14'h1010, 14'h0800, 14'h1014, 14'h1018};
        logic [31:0] ed[4] = '{32'h0, 32'h44440000, 32'd4, 32'd1};
        int  s = opAddr.size();
        int  s2;
        int  nCtl = 0;
        int  nData = 0;
        bit  ok;
        pollZeros = 0;
        tx_last_i = 1'b0;
        tx_v_i    = 1'b1;
        tx_data_i = 32'h33330000;
        waitAccept(ok);
        tx_data_i = 32'h33330001;
        waitAccept(ok);
        reset_i = 1'b1;
        tx_v_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        idle(3);
        for (int i = s; i < opAddr.size(); i++) begin
            if (opWr[i] && (opAddr[i] == 14'h1014 || opAddr[i] == 14'h1018)) nCtl++;
            if (opWr[i] && opAddr[i] >= 14'h0800 && opAddr[i] < 14'h1000) nData++;
        end
        checks++;
        if (nCtl !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_send: got %0d size/send writes want 0", nCtl);
        end
        checks++;
        if (nData !== 2) begin
            errors++;
            $display("[TB] FAIL abort_data: got %0d data writes want 2", nData);
        end
        s2 = opAddr.size();
        sendTx(1, 32'h44440000);
        idle(5);
        checks++;
        if (opAddr.size() - s2 !== 4) begin
            errors++;
            $display("[TB] FAIL abort_restart_ops: got %0d accesses want 4", opAddr.size() - s2);
        end
        for (int i = 0; i < 4; i++) begin
            if (s2 + i < opAddr.size()) begin
                checks++;
                if ({opAddr[s2+i], opData[s2+i]} !== {ea[i], ed[i]}) begin
                    errors++;
                    $display("[TB] FAIL abort_restart_op%0d: got addr=%h data=%h want addr=%h data=%h",
                             i, opAddr[s2+i], opData[s2+i], ea[i], ed[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_poll();
        test_tx_overflow();
        test_rx();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
